// File: rtl/tone_detector.sv
// -----------------------------------------------------------------------------
// tone_detector
//
// Measures the half-period of an incoming tone square wave and decodes it back
// into the 3-bit tone index (000 = do ... 111 = high do). Both edges of tone_in
// are timed. The distance between successive edges is compared against eight
// nominal half-periods with a +/-TOL window. Once enough consecutive matches on
// the same code are seen, the detector locks and reports the code.
//
// Build option:
//   TONE_DETECT_STABLE_EN  defined     : lock needs STABLE_N consecutive
//                                        identical matches.
//                          not defined : a single match locks, and a differing
//                                        match while locked relocks in place.
//
// Parameters:
//   TOL       match tolerance in clk cycles around each nominal (< 714)
//   STABLE_N  consecutive identical matches required to lock (>= 1)
//   NOM       nominal half-periods, NOM[i] belongs to code i
//
// Ports:
//   clk            system clock (50 MHz)
//   reset          synchronous active-high reset
//   tone_in        asynchronous tone square wave
//   tone_code      decoded tone index, meaningful while tone_valid = 1
//   tone_valid     high while locked to a recognised tone
//   period_out     last measured half-period in clk cycles
//   period_strobe  one-cycle pulse whenever period_out updates
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | no reference edge yet; the next edge only starts the timer
// MEASURE | timing half-periods, building a run of identical matches
// LOCKED  | reporting tone_code; leaves on a mismatch or a timeout
// -----------------------------------------------------------------------------
module tone_detector #(
    parameter int               TOL      = 200,
    parameter int               STABLE_N = 4,
    parameter logic [7:0][15:0] NOM      = {16'd23901, 16'd25330, 16'd28409, 16'd31929,
                                            16'd35817, 16'd37937, 16'd42590, 16'd47801}
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tone_in,
    output logic [2:0]  tone_code,
    output logic        tone_valid,
    output logic [15:0] period_out,
    output logic        period_strobe
);

`ifdef TONE_DETECT_STABLE_EN
    localparam int LOCK_N = STABLE_N;
`else
    // Any legal STABLE_N (>= 1) collapses to a single-match lock.
    localparam int LOCK_N = (STABLE_N > 1) ? 1 : STABLE_N;
`endif
    localparam int RUN_W = $clog2(LOCK_N + 1);

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        LOCKED
    } state_t;

    state_t             state;
    logic               sync_a;
    logic               sync_b;
    logic               sync_d;
    logic [15:0]        hp_cnt;
    logic [2:0]         cand;
    logic [RUN_W-1:0]   run;

    logic               edge_det;
    logic               timeout;
    logic [16:0]        period;
    logic [15:0]        period_sat;
    logic               hit;
    logic [2:0]         hit_code;
    logic [2:0]         cand_nx;
    logic [RUN_W-1:0]   run_nx;
    logic               lock_now;

    function automatic logic [16:0] abs_diff(input logic [16:0] a, input logic [16:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    assign edge_det   = sync_b ^ sync_d;
    // Edge wins over timeout because the counter clears on that cycle.
    assign timeout    = (hp_cnt == 16'hFFFF) && !edge_det;
    assign period     = {1'b0, hp_cnt} + 17'd1;
    assign period_sat = period[16] ? 16'hFFFF : period[15:0];

    // Scan from the top index down so the lowest matching index wins.
    always_comb begin
        hit      = 1'b0;
        hit_code = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (abs_diff(period, {1'b0, NOM[i]}) <= 17'(TOL)) begin
                hit      = 1'b1;
                hit_code = 3'(i);
            end
        end
    end

    // Run tracking for the current candidate; a hit on a new code (or on the
    // old code after the run was broken) restarts the run at one.
    always_comb begin
        cand_nx = cand;
        run_nx  = '0;
        if (hit && (hit_code == cand) && (run != '0)) begin
            run_nx = run + 1'b1;
        end else if (hit) begin
            cand_nx = hit_code;
            run_nx  = RUN_W'(1);
        end
    end

    assign lock_now = (run_nx == RUN_W'(LOCK_N));

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            sync_a        <= 1'b0;
            sync_b        <= 1'b0;
            sync_d        <= 1'b0;
            hp_cnt        <= 16'd0;
            cand          <= 3'd0;
            run           <= '0;
            tone_code     <= 3'd0;
            tone_valid    <= 1'b0;
            period_out    <= 16'd0;
            period_strobe <= 1'b0;
        end else begin
            sync_a        <= tone_in;
            sync_b        <= sync_a;
            sync_d        <= sync_b;
            period_strobe <= 1'b0;

            if (edge_det) begin
                hp_cnt <= 16'd0;
            end else if (hp_cnt != 16'hFFFF) begin
                hp_cnt <= hp_cnt + 16'd1;
            end

            if (edge_det) begin
                case (state)
                    IDLE: begin
                        // First edge has no valid reference; discard it.
                        state <= MEASURE;
                        run   <= '0;
                    end
                    MEASURE: begin
                        period_out    <= period_sat;
                        period_strobe <= 1'b1;
                        cand          <= cand_nx;
                        run           <= run_nx;
                        if (lock_now) begin
                            tone_code  <= cand_nx;
                            tone_valid <= 1'b1;
                            state      <= LOCKED;
                        end
                    end
                    LOCKED: begin
                        period_out    <= period_sat;
                        period_strobe <= 1'b1;
                        if (hit && (hit_code != tone_code)) begin
`ifdef TONE_DETECT_STABLE_EN
                            tone_valid <= 1'b0;
                            cand       <= hit_code;
                            run        <= RUN_W'(1);
                            state      <= MEASURE;
`else
                            tone_code  <= hit_code;
`endif
                        end else if (!hit) begin
                            tone_valid <= 1'b0;
                            run        <= '0;
                            state      <= MEASURE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        run   <= '0;
                    end
                endcase
            end else if (timeout) begin
                state      <= IDLE;
                tone_valid <= 1'b0;
                run        <= '0;
            end
        end
    end

endmodule

// File: tb/tb_tone_detector.sv
// -----------------------------------------------------------------------------
// tb_tone_detector
//
// Drives tone_in with directed and randomized half-periods and compares the
// detector outputs against a behavioural model. Nominal half-periods are
// scaled down by 100 so that several locks fit in a short run; the timeout
// itself is fixed by the 16-bit counter and is exercised once.
// -----------------------------------------------------------------------------
module tb_tone_detector;

    localparam int TOL      = 6;
    localparam int STABLE_N = 4;
`ifdef TONE_DETECT_STABLE_EN
    localparam int N_EFF = STABLE_N;
`else
    localparam int N_EFF = 1;
`endif

    int nom_t[8] = '{478, 426, 379, 358, 319, 284, 253, 239};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tone_in = 1'b0;
    logic [2:0]  tone_code;
    logic        tone_valid;
    logic [15:0] period_out;
    logic        period_strobe;

    always #10 clk = ~clk;

    tone_detector #(
        .TOL      (TOL),
        .STABLE_N (STABLE_N),
        .NOM      ({16'd239, 16'd253, 16'd284, 16'd319,
                    16'd358, 16'd379, 16'd426, 16'd478})
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .tone_in       (tone_in),
        .tone_code     (tone_code),
        .tone_valid    (tone_valid),
        .period_out    (period_out),
        .period_strobe (period_strobe)
    );

    int n_pass   = 0;
    int n_total  = 0;
    int n_strobe = 0;

    always @(posedge clk) begin
        if (period_strobe === 1'b1) n_strobe++;
    end

    // Reference model state
    bit  m_idle    = 1'b1;
    int  hist[$];
    bit  m_valid   = 1'b0;
    int  m_code    = 0;
    int  m_period  = 0;
    int  m_strobes = 0;
    int  prev_gap  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int match_of(input int p);
        for (int i = 0; i < 8; i++) begin
            int d;
            d = (p > nom_t[i]) ? p - nom_t[i] : nom_t[i] - p;
            if (d <= TOL) return i;
        end
        return -1;
    endfunction

    // Locked whenever the trailing run of identical matches since the last
    // idle period is at least N_EFF long; the code follows that run.
    task automatic model_edge();
        int s;
        if (m_idle) begin
            m_idle = 1'b0;
        end else begin
            m_strobes++;
            m_period = prev_gap & 32'hFFFF;
            hist.push_back(match_of(prev_gap));
            s = 0;
            if (hist[$] >= 0) begin
                for (int i = hist.size() - 1; i >= 0; i--) begin
                    if (hist[i] != hist[$]) break;
                    s++;
                end
            end
            m_valid = (s >= N_EFF);
            if (m_valid) m_code = hist[$];
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"},  {31'd0, tone_valid}, {31'd0, m_valid});
        chk({tag, ".code"},   {29'd0, tone_code},  m_code);
        chk({tag, ".period"}, {16'd0, period_out}, m_period);
        chk({tag, ".strobes"}, n_strobe, m_strobes);
    endtask

    task automatic step(input string tag, input int gap);
        tone_in = ~tone_in;
        model_edge();
        repeat (gap) @(posedge clk);
        #1;
        prev_gap = gap;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        reset   = 1'b1;
        tone_in = 1'b1;
        @(posedge clk);
        #1;
        tone_in = 1'b0;
        @(posedge clk);
        #1;
        m_idle   = 1'b1;
        hist.delete();
        m_valid  = 1'b0;
        m_code   = 0;
        m_period = 0;
        check_all(tag);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        do_reset("reset");

        // Lock on code 5
        for (int i = 0; i < 5; i++) step("lock5", 284);
        chk("lock5.final_valid", {31'd0, tone_valid}, 32'd1);
        chk("lock5.final_code", {29'd0, tone_code}, 32'd5);

        // Retune to code 1
        for (int i = 0; i < 6; i++) step("retune1", 426);
        chk("retune1.final_code", {29'd0, tone_code}, 32'd1);

        // Back to 5, then a single out-of-window period
        for (int i = 0; i < 6; i++) step("relock5", 284);
        step("oow", 300);
        for (int i = 0; i < 5; i++) step("oow_relock", 284);

        // Tolerance boundary on code 0
        for (int i = 0; i < 5; i++) step("tol_in", 484);
        chk("tol_in.final_code", {29'd0, tone_code}, 32'd0);
        for (int i = 0; i < 5; i++) step("tol_out", 485);
        chk("tol_out.final_valid", {31'd0, tone_valid}, 32'd0);

        // Relock, then stop toggling
        for (int i = 0; i < 5; i++) step("pre_to", 284);
        tone_in = ~tone_in;
        model_edge();
        repeat (65000) @(posedge clk);
        #1;
        chk("to_hold.valid", {31'd0, tone_valid}, {31'd0, m_valid});
        repeat (1000) @(posedge clk);
        #1;
        prev_gap = 66000;
        m_idle   = 1'b1;
        hist.delete();
        m_valid  = 1'b0;
        check_all("to_drop");
        step("to_discard", 300);
        for (int i = 0; i < 5; i++) step("post_to", 253);

        // Randomized bursts
        for (int b = 0; b < 8; b++) begin
            int c;
            int n;
            c = int'($urandom_range(7));
            n = int'($urandom_range(1, 5));
            for (int k = 0; k < n; k++) begin
                int g;
                if ($urandom_range(9) == 0) g = int'($urandom_range(230, 490));
                else g = nom_t[c] + int'($urandom_range(0, 2 * TOL)) - TOL;
                step("rand", g);
            end
        end

        // Reset in the middle of a half-period
        tone_in = ~tone_in;
        model_edge();
        repeat (100) @(posedge clk);
        #1;
        do_reset("mid_reset");
        for (int i = 0; i < 6; i++) step("after_reset", 239);
        chk("after_reset.final_code", {29'd0, tone_code}, 32'd7);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
